mst_fifo_slv_rsp: RTL and testbench
===================================

Name: mst_fifo_slv_rsp

Overview:
Synthesizable chip-side responder for the 245-mode master FIFO bus. It models the FT60x end of the bus driven by the FPGA master FSM: it generates txe_n/rxf_n, sources read data when the master asserts oe_n/rd_n, and sinks write data when the master asserts wr_n. It sits in the loopback/self-test build in place of the external chip, and is fed and drained by a test-side buffer interface or an internal stream pattern generator.

Parameters:
DEPTH_LOG2, 4, log2 of source and sink buffer depth in 36/37-bit words (depth 16).
TXE_HOLD, 2, cycles txe_n is held high after the sink buffer stops being full (models chip buffer turnaround).

Ports:
clk  input  1  bus clock (66/100 MHz FIFO clock)
rst  input  1  synchronous reset, active-high
wr_n  input  1  master write strobe, active-low
rd_n  input  1  master read strobe, active-low
oe_n  input  1  master output-enable request, active-low
idata  input  32  data driven by master during writes
ibe  input  4  byte enables driven by master during writes
txe_n  output  1  sink space available, active-low
rxf_n  output  1  source data available, active-low
odata  output  32  data driven towards master during reads
obe  output  4  byte enables driven towards master during reads
dt_oe  output  1  responder drives data bus
be_oe  output  1  responder drives BE bus
strm_en  input  1  source from internal incrementing pattern instead of buffer
src_wr  input  1  push a word into the source buffer
src_wdat  input  36  {be[3:0], data[31:0]} to push
src_full  output  1  source buffer full
snk_rd  input  1  pop a word from the sink buffer
snk_rdat  output  37  {pkt_end, be[3:0], data[31:0]} at sink head
snk_nempt  output  1  sink buffer non-empty
proto_err  output  1  sticky protocol violation flag
drop_cnt  output  16  count of writes accepted by the master while txe_n was high

Behaviour:
- Reset (rst high at clk edge): both buffers empty, txe_n=1, rxf_n=1, odata=32'hFFFF_FFFF, obe=4'hF, dt_oe=0, be_oe=0, src_full=0, snk_nempt=0, snk_rdat=0, proto_err=0, drop_cnt=0, pattern counter=0. Reset mid-transfer discards all buffer contents; no partial words are retained.
- All bus outputs are registered; inputs are sampled at clk rising edge.
- Source path: rxf_n <= 0 when the source holds >=1 word after this cycle's push/pop, or when strm_en=1; otherwise 1. The head word is presented on odata/obe at all times while dt_oe=1.
- dt_oe/be_oe <= (!oe_n & wr_n). Pop condition: rd_n==0 & oe_n==0 & rxf_n==0 (all sampled). Each pop advances the head; odata shows the next word in the following cycle (one word per cycle, zero-wait burst).
- Pop when the source is empty (rd_n low while rxf_n high) has no effect on buffer state and sets proto_err.
- strm_en=1: odata=pattern counter, obe=4'hF, and the counter increments by 1 per pop (wrapping at 2^32). The source buffer is untouched.
- Sink path: write condition is wr_n==0 with the sampled txe_n==0. Stores {pkt_end, ibe, idata} with pkt_end=(ibe!=4'hF), i.e. a short write terminates the packet.
- txe_n <= 1 when free space after this cycle is 0. When space becomes available again, txe_n returns low only after TXE_HOLD consecutive non-full cycles.
- wr_n==0 while the sampled txe_n==1: the word is dropped and drop_cnt increments, saturating at 16'hFFFF.
- wr_n==0 & oe_n==0 in the same cycle (bus contention) sets proto_err. In that case the write is still evaluated, and dt_oe is forced to 0.
- Simultaneous push and pop on the same buffer is allowed in the same cycle; occupancy is unchanged.
- Pointer wrap is modulo depth. Full and empty are distinguished by an extra pointer bit.
- src_wr while src_full is ignored.
- snk_rd while empty is ignored. snk_rdat is valid whenever snk_nempt=1 (first-word fall-through).
- proto_err clears only on rst.

Test Plan:
- Reset then idle: after rst, txe_n=1 for TXE_HOLD cycles, then txe_n=0. rxf_n=1, odata=32'hFFFF_FFFF, dt_oe=0.
- Read burst: push 3 words {F,0x11111111},{F,0x22222222},{3,0x33333333}, then hold oe_n=0 and rd_n=0 for 3 cycles → odata sequence 0x11111111, 0x22222222, 0x33333333; obe ends at 4'h3; rxf_n=1 the cycle after the third pop.
- Write to full: 16 writes with ibe=F, then a 17th write → txe_n=1 after the 16th write; 17th is dropped with drop_cnt=1. Pop one word via snk_rd → txe_n=0 TXE_HOLD cycles later.
- Short packet: write 0xAABBCCDD with ibe=4'h1 → snk_rdat={1,4'h1,0xAABBCCDD}, snk_nempt=1.
- Stream mode: strm_en=1 with 5 pops → odata 0,1,2,3,4; rxf_n held 0; source buffer count unchanged.
- Contention: wr_n=0 and oe_n=0 in the same cycle → proto_err=1 and dt_oe=0. proto_err stays 1 until rst.

Source files
------------

// File: rtl/mst_fifo_slv_rsp.sv
// Chip-side responder for the 245-mode master FIFO bus.
// Stands in for the FT60x: a source buffer (or stream pattern) feeds master
// reads, and a sink buffer absorbs master writes with txe_n backpressure.
module mst_fifo_slv_rsp #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TXE_HOLD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        oe_n,
  input  logic [31:0] idata,
  input  logic [3:0]  ibe,
  output logic        txe_n,
  output logic        rxf_n,
  output logic [31:0] odata,
  output logic [3:0]  obe,
  output logic        dt_oe,
  output logic        be_oe,
  input  logic        strm_en,
  input  logic        src_wr,
  input  logic [35:0] src_wdat,
  output logic        src_full,
  input  logic        snk_rd,
  output logic [36:0] snk_rdat,
  output logic        snk_nempt,
  output logic        proto_err,
  output logic [15:0] drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;   // extra bit separates full from empty

  // Buffer storage (no reset: contents are invalidated via the pointers)
  logic [35:0] src_mem [DEPTH];
  logic [36:0] snk_mem [DEPTH];

  logic [PW-1:0] src_wp_q, src_wp_d, src_rp_q, src_rp_d;
  logic [PW-1:0] snk_wp_q, snk_wp_d, snk_rp_q, snk_rp_d;
  logic          txe_n_q, txe_n_d;
  logic          rxf_n_q, rxf_n_d;
  logic [31:0]   odata_q, odata_d;
  logic [3:0]    obe_q, obe_d;
  logic          dt_oe_q, dt_oe_d;
  logic          proto_err_q, proto_err_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   pat_q, pat_d;
  logic [7:0]    hold_q, hold_d;

  logic src_empty, src_full_w, src_push, src_pop, src_nempty_next;
  logic snk_empty, snk_full_w, snk_push, snk_pop, snk_full_next, snk_drop;
  logic bus_rd, pat_inc, hold_done;
  logic [35:0] src_head;
  logic [36:0] snk_wdat;

  // Occupancy flags and transfer qualifiers for both buffers
  always_comb begin
    src_empty  = (src_wp_q == src_rp_q);
    src_full_w = (src_wp_q[PW-1] != src_rp_q[PW-1]) &&
                 (src_wp_q[PW-2:0] == src_rp_q[PW-2:0]);
    snk_empty  = (snk_wp_q == snk_rp_q);
    snk_full_w = (snk_wp_q[PW-1] != snk_rp_q[PW-1]) &&
                 (snk_wp_q[PW-2:0] == snk_rp_q[PW-2:0]);

    bus_rd   = ~rd_n & ~oe_n & ~rxf_n_q;
    pat_inc  = bus_rd & strm_en;
    src_pop  = bus_rd & ~strm_en & ~src_empty;
    src_push = src_wr & ~src_full_w;

    // txe_n as seen by the master gates writes; a write against high txe_n is lost
    snk_push = ~wr_n & ~txe_n_q & ~snk_full_w;
    snk_drop = ~wr_n & txe_n_q;
    snk_pop  = snk_rd & ~snk_empty;
    snk_wdat = {(ibe != 4'hF), ibe, idata};

    src_head = src_mem[src_rp_q[PW-2:0]];
  end

  // Next-state for pointers, bus outputs, flags and counters
  always_comb begin
    src_wp_d = src_wp_q + {{(PW-1){1'b0}}, src_push};
    src_rp_d = src_rp_q + {{(PW-1){1'b0}}, src_pop};
    snk_wp_d = snk_wp_q + {{(PW-1){1'b0}}, snk_push};
    snk_rp_d = snk_rp_q + {{(PW-1){1'b0}}, snk_pop};

    src_nempty_next = (src_wp_d != src_rp_d);
    snk_full_next   = (snk_wp_d[PW-1] != snk_rp_d[PW-1]) &&
                      (snk_wp_d[PW-2:0] == snk_rp_d[PW-2:0]);

    rxf_n_d = ~(src_nempty_next | strm_en);

    // Drive only when the master asks and is not itself writing
    dt_oe_d = ~oe_n & wr_n;
    odata_d = 32'hFFFF_FFFF;
    obe_d   = 4'hF;
    if (dt_oe_d) begin
      if (strm_en) begin
        odata_d = pat_q;
        obe_d   = 4'hF;
      end else if (!src_empty) begin
        odata_d = src_head[31:0];
        obe_d   = src_head[35:32];
      end
    end

    pat_d = pat_q + {31'd0, pat_inc};

    proto_err_d = proto_err_q | (~wr_n & ~oe_n) | (~rd_n & rxf_n_q);

    drop_cnt_d = drop_cnt_q;
    if (snk_drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // txe_n rises immediately on full, falls only after TXE_HOLD non-full cycles
    hold_done = (int'(hold_q) + 1 >= TXE_HOLD);
    txe_n_d   = txe_n_q;
    hold_d    = 8'd0;
    if (snk_full_next) begin
      txe_n_d = 1'b1;
    end else if (txe_n_q) begin
      if (hold_done) begin
        txe_n_d = 1'b0;
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      src_wp_q    <= '0;
      src_rp_q    <= '0;
      snk_wp_q    <= '0;
      snk_rp_q    <= '0;
      txe_n_q     <= 1'b1;
      rxf_n_q     <= 1'b1;
      odata_q     <= 32'hFFFF_FFFF;
      obe_q       <= 4'hF;
      dt_oe_q     <= 1'b0;
      proto_err_q <= 1'b0;
      drop_cnt_q  <= 16'd0;
      pat_q       <= 32'd0;
      hold_q      <= 8'd0;
    end else begin
      src_wp_q    <= src_wp_d;
      src_rp_q    <= src_rp_d;
      snk_wp_q    <= snk_wp_d;
      snk_rp_q    <= snk_rp_d;
      txe_n_q     <= txe_n_d;
      rxf_n_q     <= rxf_n_d;
      odata_q     <= odata_d;
      obe_q       <= obe_d;
      dt_oe_q     <= dt_oe_d;
      proto_err_q <= proto_err_d;
      drop_cnt_q  <= drop_cnt_d;
      pat_q       <= pat_d;
      hold_q      <= hold_d;
    end
  end

  // Source buffer write port
  always_ff @(posedge clk) begin
    if (src_push) begin
      src_mem[src_wp_q[PW-2:0]] <= src_wdat;
    end
  end

  // Sink buffer write port
  always_ff @(posedge clk) begin
    if (snk_push) begin
      snk_mem[snk_wp_q[PW-2:0]] <= snk_wdat;
    end
  end

  assign txe_n     = txe_n_q;
  assign rxf_n     = rxf_n_q;
  assign odata     = odata_q;
  assign obe       = obe_q;
  assign dt_oe     = dt_oe_q;
  assign be_oe     = dt_oe_q;
  assign src_full  = src_full_w;
  assign snk_nempt = ~snk_empty;
  assign snk_rdat  = snk_empty ? 37'd0 : snk_mem[snk_rp_q[PW-2:0]];
  assign proto_err = proto_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mst_fifo_slv_rsp.sv
// Testbench for mst_fifo_slv_rsp: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_mst_fifo_slv_rsp;

  localparam int DEPTH    = 16;
  localparam int TXE_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst, wr_n, rd_n, oe_n, strm_en, src_wr, snk_rd;
  logic [31:0] idata;
  logic [3:0]  ibe;
  logic [35:0] src_wdat;
  logic        txe_n, rxf_n, dt_oe, be_oe, src_full, snk_nempt, proto_err;
  logic [31:0] odata;
  logic [3:0]  obe;
  logic [36:0] snk_rdat;
  logic [15:0] drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mst_fifo_slv_rsp #(.DEPTH_LOG2(4), .TXE_HOLD(TXE_HOLD)) dut (
    .clk(clk), .rst(rst), .wr_n(wr_n), .rd_n(rd_n), .oe_n(oe_n),
    .idata(idata), .ibe(ibe), .txe_n(txe_n), .rxf_n(rxf_n),
    .odata(odata), .obe(obe), .dt_oe(dt_oe), .be_oe(be_oe),
    .strm_en(strm_en), .src_wr(src_wr), .src_wdat(src_wdat),
    .src_full(src_full), .snk_rd(snk_rd), .snk_rdat(snk_rdat),
    .snk_nempt(snk_nempt), .proto_err(proto_err), .drop_cnt(drop_cnt)
  );

  // ---------------- reference model ----------------
  logic [35:0] m_src[$];
  logic [36:0] m_snk[$];
  logic        m_txe_n, m_rxf_n, m_dt, m_perr;
  logic [31:0] m_odata, m_pat;
  logic [3:0]  m_obe;
  logic [15:0] m_drop;
  int          m_streak;

  task automatic model_step();
    int src_n, snk_n;
    logic popping;
    if (rst) begin
      m_src.delete(); m_snk.delete();
      m_txe_n = 1; m_rxf_n = 1; m_dt = 0; m_perr = 0;
      m_odata = 32'hFFFF_FFFF; m_obe = 4'hF; m_drop = 0; m_pat = 0; m_streak = 0;
      return;
    end
    src_n   = m_src.size();
    snk_n   = m_snk.size();
    popping = !rd_n && !oe_n && !m_rxf_n;
    m_perr  = m_perr | (!wr_n && !oe_n) | (!rd_n && m_rxf_n);
    m_odata = 32'hFFFF_FFFF; m_obe = 4'hF; m_dt = 0;
    if (!oe_n && wr_n) begin
      m_dt = 1;
      if (strm_en) m_odata = m_pat;
      else if (src_n > 0) begin
        m_odata = m_src[0][31:0];
        m_obe   = m_src[0][35:32];
      end
    end
    if (popping) begin
      if (strm_en) m_pat = m_pat + 1;
      else if (src_n > 0) void'(m_src.pop_front());
    end
    if (src_wr && src_n < DEPTH) m_src.push_back(src_wdat);
    if (!wr_n) begin
      if (m_txe_n) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
      end else if (snk_n < DEPTH) begin
        m_snk.push_back({(ibe != 4'hF), ibe, idata});
      end
    end
    if (snk_rd && snk_n > 0) void'(m_snk.pop_front());
    if (m_snk.size() == DEPTH) begin
      m_txe_n = 1; m_streak = 0;
    end else if (m_txe_n) begin
      m_streak++;
      if (m_streak >= TXE_HOLD) begin m_txe_n = 0; m_streak = 0; end
    end
    m_rxf_n = !(m_src.size() > 0 || strm_en);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_model();
    logic [36:0] exp_rdat;
    exp_rdat = (m_snk.size() > 0) ? m_snk[0] : 37'd0;
    check("txe_n",     64'(txe_n),     64'(m_txe_n));
    check("rxf_n",     64'(rxf_n),     64'(m_rxf_n));
    check("odata",     64'(odata),     64'(m_odata));
    check("obe",       64'(obe),       64'(m_obe));
    check("dt_oe",     64'(dt_oe),     64'(m_dt));
    check("be_oe",     64'(be_oe),     64'(m_dt));
    check("src_full",  64'(src_full),  64'(m_src.size() == DEPTH));
    check("snk_nempt", 64'(snk_nempt), 64'(m_snk.size() > 0));
    check("snk_rdat",  64'(snk_rdat),  64'(exp_rdat));
    check("proto_err", 64'(proto_err), 64'(m_perr));
    check("drop_cnt",  64'(drop_cnt),  64'(m_drop));
  endtask

  // One clock: inputs already driven; update model at the edge, sample at negedge
  task automatic step(input bit chk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk) check_model();
  endtask

  task automatic idle_inputs();
    rst = 0; wr_n = 1; rd_n = 1; oe_n = 1; strm_en = 0; src_wr = 0; snk_rd = 0;
    idata = 0; ibe = 4'hF; src_wdat = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        rst, wr_n, rd_n, oe_n, src_wr;
    logic [35:0] src_wdat;
    logic [31:0] idata;
    logic [3:0]  ibe;
    logic        e_txe_n, e_rxf_n;
    logic [31:0] e_odata;
    logic [3:0]  e_obe;
    logic        e_dt, e_perr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [42:0] act, exp;
    // rst wr rd oe swr  src_wdat              idata          ibe  | txe rxf odata           obe  dt perr
    tbl[0]  = '{1,1,1,1,0, 36'h0,                32'h0,         4'hF, 1,1, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[1]  = '{0,1,1,1,0, 36'h0,                32'h0,         4'hF, 1,1, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[2]  = '{0,1,1,1,0, 36'h0,                32'h0,         4'hF, 0,1, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[3]  = '{0,1,1,1,1, {4'hF,32'h1111_1111}, 32'h0,         4'hF, 0,0, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[4]  = '{0,1,1,1,1, {4'hF,32'h2222_2222}, 32'h0,         4'hF, 0,0, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[5]  = '{0,1,1,1,1, {4'h3,32'h3333_3333}, 32'h0,         4'hF, 0,0, 32'hFFFF_FFFF, 4'hF, 0,0};
    tbl[6]  = '{0,1,0,0,0, 36'h0,                32'h0,         4'hF, 0,0, 32'h1111_1111, 4'hF, 1,0};
    tbl[7]  = '{0,1,0,0,0, 36'h0,                32'h0,         4'hF, 0,0, 32'h2222_2222, 4'hF, 1,0};
    tbl[8]  = '{0,1,0,0,0, 36'h0,                32'h0,         4'hF, 0,1, 32'h3333_3333, 4'h3, 1,0};
    tbl[9]  = '{0,1,1,0,0, 36'h0,                32'h0,         4'hF, 0,1, 32'hFFFF_FFFF, 4'hF, 1,0};
    tbl[10] = '{0,0,1,0,0, 36'h0,                32'h1234_5678, 4'hF, 0,1, 32'hFFFF_FFFF, 4'hF, 0,1};
    tbl[11] = '{0,1,1,1,0, 36'h0,                32'h0,         4'hF, 0,1, 32'hFFFF_FFFF, 4'hF, 0,1};
    tbl[12] = '{1,1,1,1,0, 36'h0,                32'h0,         4'hF, 1,1, 32'hFFFF_FFFF, 4'hF, 0,0};

    idle_inputs();
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; wr_n = tbl[i].wr_n; rd_n = tbl[i].rd_n; oe_n = tbl[i].oe_n;
      src_wr = tbl[i].src_wr; src_wdat = tbl[i].src_wdat;
      idata = tbl[i].idata; ibe = tbl[i].ibe;
      step(0);
      act = {txe_n, rxf_n, odata, obe, dt_oe, be_oe, proto_err};
      exp = {tbl[i].e_txe_n, tbl[i].e_rxf_n, tbl[i].e_odata, tbl[i].e_obe,
             tbl[i].e_dt, tbl[i].e_dt, tbl[i].e_perr};
      check($sformatf("vec%0d", i), 64'(act), 64'(exp));
      $display("vec %0d: txe_n=%b rxf_n=%b odata=%h obe=%h dt_oe=%b proto_err=%b",
               i, txe_n, rxf_n, odata, obe, dt_oe, proto_err);
    end

    // ---- write to full, drop, recover ----
    idle_inputs();
    step(1); step(1);
    for (int i = 0; i < DEPTH; i++) begin
      wr_n = 0; idata = 32'h100 + i; ibe = 4'hF;
      step(1);
    end
    check("full_txe_n", 64'(txe_n), 64'd1);
    idata = 32'hDEAD_BEEF;
    step(1);
    check("drop_cnt_1", 64'(drop_cnt), 64'd1);
    check("full_head", 64'(snk_rdat), 64'({1'b0, 4'hF, 32'h100}));
    wr_n = 1; snk_rd = 1;
    step(1);
    check("txe_hold_1", 64'(txe_n), 64'd1);
    snk_rd = 0;
    step(1);
    check("txe_release", 64'(txe_n), 64'd0);
    $display("write-to-full: drop_cnt=%0d txe_n=%b", drop_cnt, txe_n);

    // ---- short packet ----
    rst = 1; step(1); rst = 0;
    step(1); step(1);
    wr_n = 0; idata = 32'hAABB_CCDD; ibe = 4'h1;
    step(1);
    wr_n = 1; ibe = 4'hF;
    check("short_rdat", 64'(snk_rdat), 64'({1'b1, 4'h1, 32'hAABB_CCDD}));
    check("short_nempt", 64'(snk_nempt), 64'd1);
    $display("short packet: snk_rdat=%h", snk_rdat);

    // ---- stream mode leaves the source buffer alone ----
    rst = 1; step(1); rst = 0;
    src_wr = 1; src_wdat = {4'hF, 32'hCAFE_F00D};
    step(1);
    src_wr = 0; strm_en = 1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      oe_n = 0; rd_n = 0;
      step(1);
      check($sformatf("strm_odata%0d", i), 64'(odata), 64'(i));
      check($sformatf("strm_rxf%0d", i), 64'(rxf_n), 64'd0);
      $display("stream pop %0d: odata=%h rxf_n=%b", i, odata, rxf_n);
    end
    strm_en = 0; rd_n = 1;
    step(1);
    check("strm_src_kept", 64'(odata), 64'h0_CAFE_F00D);
    oe_n = 1;

    // ---- contention sticks until reset ----
    wr_n = 0; oe_n = 0;
    step(1);
    wr_n = 1; oe_n = 1;
    step(1); step(1);
    check("perr_sticky", 64'(proto_err), 64'd1);
    check("perr_dt_oe", 64'(dt_oe), 64'd0);

    // ---- randomized traffic against the model ----
    rst = 1; step(1); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      wr_n    = ($urandom_range(0, 9) >= 4);
      oe_n    = ($urandom_range(0, 9) >= 3);
      rd_n    = ($urandom_range(0, 9) >= 3);
      if ($urandom_range(0, 49) == 0) strm_en = ~strm_en;
      src_wr  = $urandom_range(0, 1);
      src_wdat = {4'($urandom), $urandom};
      idata   = $urandom;
      ibe     = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      snk_rd  = ($urandom_range(0, 9) >= 6);
      step(1);
      if (c % 500 == 0)
        $display("random cycle %0d: txe_n=%b rxf_n=%b drop_cnt=%0d proto_err=%b",
                 c, txe_n, rxf_n, drop_cnt, proto_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
